// File: rtl/regfile_sb.sv
// Multi-port register file with byte strobes, same-cycle write forwarding and a
// per-register busy scoreboard for tracking pending writes.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     raddr1,
    input  logic [ADDR_W-1:0]     raddr2,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    input  logic                  wen,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  alloc_en,
    input  logic [ADDR_W-1:0]     alloc_addr,
    output logic                  alloc_ok,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

    logic              wr_hit;
    logic              alloc_set;
    logic              net_set, net_clr;
    logic [DATA_W-1:0] wr_merged;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     strb
    );
        logic [DATA_W-1:0] m;
        m = old_v;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) m[8*i +: 8] = new_v[8*i +: 8];
        end
        return m;
    endfunction

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    assign wr_hit    = wen && writable(waddr);
    assign wr_merged = byte_merge(regs_q[waddr], wdata, wstrb);

    always_comb begin
        rdata1 = writable(raddr1) ? regs_q[raddr1] : '0;
        rdata2 = writable(raddr2) ? regs_q[raddr2] : '0;
        if (BYPASS != 0 && wr_hit && raddr1 == waddr) rdata1 = wr_merged;
        if (BYPASS != 0 && wr_hit && raddr2 == waddr) rdata2 = wr_merged;
        rbusy1 = busy_q[raddr1] && !(BYPASS != 0 && wen && waddr == raddr1);
        rbusy2 = busy_q[raddr2] && !(BYPASS != 0 && wen && waddr == raddr2);
    end

    // A busy register can be re-allocated only by the write that retires it.
    assign alloc_ok  = !busy_q[alloc_addr] || (wen && waddr == alloc_addr);
    assign alloc_set = alloc_en && alloc_ok && writable(alloc_addr);

    always_comb begin
        busy_d = busy_q;
        if (wr_hit)    busy_d[waddr]      = 1'b0;
        if (alloc_set) busy_d[alloc_addr] = 1'b1;
    end

    // Clear-and-set of one address cancels out, so the count is left alone.
    assign net_set = alloc_set && !busy_q[alloc_addr];
    assign net_clr = wr_hit && busy_q[waddr] && !(alloc_set && alloc_addr == waddr);
    assign busy_cnt_d = busy_cnt_q + CNT_W'(net_set) - CNT_W'(net_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_hit) regs_q[waddr] <= wr_merged;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] raddr1, raddr2, waddr, alloc_addr;
    logic [DW-1:0] rdata1, rdata2, wdata;
    logic          rbusy1, rbusy2, wen, alloc_en, alloc_ok;
    logic [3:0]    wstrb;
    logic [AW:0]   busy_cnt;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_reg  [NR];
    bit          m_busy [NR];

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2),
        .wen(wen), .waddr(waddr), .wstrb(wstrb), .wdata(wdata),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .alloc_ok(alloc_ok), .busy_cnt(busy_cnt)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = old_v;
        for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = new_v[8*i +: 8];
        return m;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [AW-1:0] a);
        if (a == 0) return 32'h0;
        if (wen && waddr == a) return merge(m_reg[a], wdata, wstrb);
        return m_reg[a];
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] a);
        if (wen && waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ok();
        return !m_busy[alloc_addr] || (wen && waddr == alloc_addr);
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < NR; i++) if (m_busy[i]) c++;
        return (AW+1)'(c);
    endfunction

    // Advance the model with the inputs presented this cycle, then clock the DUT.
    task automatic tick();
        logic ok;
        ok = exp_ok();
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wen && waddr != 0) begin
                m_reg[waddr]  = merge(m_reg[waddr], wdata, wstrb);
                m_busy[waddr] = 1'b0;
            end
            if (alloc_en && ok && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wen = 1'b0; alloc_en = 1'b0; wstrb = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wen = 1'b1; waddr = 5'd2; wstrb = 4'hF; wdata = 32'hCAFEF00D;
        alloc_en = 1'b1; alloc_addr = 5'd2; raddr1 = 5'd2; raddr2 = 5'd9;
        tick();
        idle();
        #1;
        total++; if (rdata1 !== 32'h0) $display("FAIL reset_rdata1 got %h want 0", rdata1); else passed++;
        total++; if (rbusy1 !== 1'b0) $display("FAIL reset_rbusy1 got %b want 0", rbusy1); else passed++;
        total++; if (busy_cnt !== '0) $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt); else passed++;
        tick();
        total++; if (rdata2 !== 32'h0) $display("FAIL reset_hold_rdata2 got %h want 0", rdata2); else passed++;
    endtask

    task automatic test_write_read();
        wen = 1'b1; waddr = 5'd3; wstrb = 4'hF; wdata = 32'hDEADBEEF;
        tick();
        idle();
        raddr1 = 5'd3;
        #1;
        total++; if (rdata1 !== 32'hDEADBEEF) $display("FAIL write_read got %h want deadbeef", rdata1); else passed++;
    endtask

    task automatic test_strobe_bypass();
        wen = 1'b1; waddr = 5'd5; wstrb = 4'hF; wdata = 32'h11223344;
        tick();
        wstrb = 4'b0101; wdata = 32'hAABBCCDD; raddr2 = 5'd5;
        #1;
        total++; if (rdata2 !== 32'h11BB33DD) $display("FAIL bypass_rdata2 got %h want 11bb33dd", rdata2); else passed++;
        tick();
        idle();
        raddr1 = 5'd5;
        #1;
        total++; if (rdata1 !== 32'h11BB33DD) $display("FAIL strobe_r5 got %h want 11bb33dd", rdata1); else passed++;
    endtask

    task automatic test_zero_reg();
        wen = 1'b1; waddr = 5'd0; wstrb = 4'hF; wdata = 32'hFFFFFFFF;
        tick();
        idle();
        raddr1 = 5'd0;
        #1;
        total++; if (rdata1 !== 32'h0) $display("FAIL zero_read got %h want 0", rdata1); else passed++;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        #1;
        total++; if (alloc_ok !== 1'b1) $display("FAIL zero_alloc_ok got %b want 1", alloc_ok); else passed++;
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== '0) $display("FAIL zero_busy_cnt got %0d want 0", busy_cnt); else passed++;
        total++; if (rbusy1 !== 1'b0) $display("FAIL zero_rbusy got %b want 0", rbusy1); else passed++;
    endtask

    task automatic test_alloc();
        alloc_en = 1'b1; alloc_addr = 5'd7;
        tick();
        idle();
        raddr1 = 5'd7;
        #1;
        total++; if (busy_cnt !== 6'd1) $display("FAIL alloc_cnt got %0d want 1", busy_cnt); else passed++;
        total++; if (rbusy1 !== 1'b1) $display("FAIL alloc_rbusy got %b want 1", rbusy1); else passed++;
        alloc_en = 1'b1; alloc_addr = 5'd7;
        #1;
        total++; if (alloc_ok !== 1'b0) $display("FAIL realloc_ok got %b want 0", alloc_ok); else passed++;
        tick();
        wen = 1'b1; waddr = 5'd7; wstrb = 4'h0; wdata = 32'h12345678;
        #1;
        total++; if (alloc_ok !== 1'b1) $display("FAIL wr_alloc_ok got %b want 1", alloc_ok); else passed++;
        total++; if (rbusy1 !== 1'b0) $display("FAIL wr_bypass_rbusy got %b want 0", rbusy1); else passed++;
        tick();
        idle();
        #1;
        total++; if (rbusy1 !== 1'b1) $display("FAIL wr_alloc_busy got %b want 1", rbusy1); else passed++;
        total++; if (busy_cnt !== 6'd1) $display("FAIL wr_alloc_cnt got %0d want 1", busy_cnt); else passed++;
        wen = 1'b1; waddr = 5'd7; wstrb = 4'hF; wdata = 32'h0;
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== 6'd0) $display("FAIL retire7_cnt got %0d want 0", busy_cnt); else passed++;
    endtask

    task automatic test_alloc_write_diff();
        alloc_en = 1'b1; alloc_addr = 5'd4;
        wen = 1'b1; waddr = 5'd9; wstrb = 4'hF; wdata = 32'h0BADC0DE;
        tick();
        idle();
        raddr1 = 5'd9; raddr2 = 5'd4;
        #1;
        total++; if (busy_cnt !== 6'd1) $display("FAIL diff_cnt got %0d want 1", busy_cnt); else passed++;
        total++; if (rdata1 !== 32'h0BADC0DE) $display("FAIL diff_r9 got %h want 0badc0de", rdata1); else passed++;
        total++; if (rbusy2 !== 1'b1) $display("FAIL diff_busy4 got %b want 1", rbusy2); else passed++;
        wen = 1'b1; waddr = 5'd4; wstrb = 4'h3; wdata = 32'h00005555;
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== 6'd0) $display("FAIL diff_retire_cnt got %0d want 0", busy_cnt); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            wen        = ($urandom_range(0, 2) != 0);
            alloc_en   = ($urandom_range(0, 1) != 0);
            wstrb      = 4'($urandom);
            wdata      = $urandom;
            if ($urandom_range(0, 1) != 0) begin
                waddr = AW'($urandom_range(0, 7)); alloc_addr = AW'($urandom_range(0, 7));
                raddr1 = AW'($urandom_range(0, 7)); raddr2 = AW'($urandom_range(0, 7));
            end else begin
                waddr = AW'($urandom); alloc_addr = AW'($urandom);
                raddr1 = AW'($urandom); raddr2 = AW'($urandom);
            end
            #1;
            total++; if (rdata1 !== exp_rdata(raddr1)) $display("FAIL rnd_rdata1 n=%0d got %h want %h", n, rdata1, exp_rdata(raddr1)); else passed++;
            total++; if (rdata2 !== exp_rdata(raddr2)) $display("FAIL rnd_rdata2 n=%0d got %h want %h", n, rdata2, exp_rdata(raddr2)); else passed++;
            total++; if (rbusy1 !== exp_rbusy(raddr1)) $display("FAIL rnd_rbusy1 n=%0d got %b want %b", n, rbusy1, exp_rbusy(raddr1)); else passed++;
            total++; if (rbusy2 !== exp_rbusy(raddr2)) $display("FAIL rnd_rbusy2 n=%0d got %b want %b", n, rbusy2, exp_rbusy(raddr2)); else passed++;
            total++; if (alloc_ok !== exp_ok()) $display("FAIL rnd_alloc_ok n=%0d got %b want %b", n, alloc_ok, exp_ok()); else passed++;
            total++; if (busy_cnt !== exp_cnt()) $display("FAIL rnd_busy_cnt n=%0d got %0d want %0d", n, busy_cnt, exp_cnt()); else passed++;
            tick();
        end
        idle();
    endtask

    task automatic test_reset_full();
        for (int a = 1; a < NR; a++) begin
            alloc_en = 1'b1; alloc_addr = AW'(a);
            tick();
        end
        idle();
        #1;
        total++; if (busy_cnt !== 6'd31) $display("FAIL full_cnt got %0d want 31", busy_cnt); else passed++;
        rst = 1'b1; wen = 1'b1; waddr = 5'd2; wstrb = 4'hF; wdata = 32'hA5A5A5A5;
        alloc_en = 1'b1; alloc_addr = 5'd2;
        tick();
        idle();
        #1;
        total++; if (busy_cnt !== 6'd0) $display("FAIL full_rst_cnt got %0d want 0", busy_cnt); else passed++;
        for (int a = 0; a < NR; a++) begin
            raddr1 = AW'(a);
            #1;
            total++; if (rbusy1 !== 1'b0 || rdata1 !== 32'h0)
                $display("FAIL full_rst_clear a=%0d got busy=%b data=%h want busy=0 data=0", a, rbusy1, rdata1);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            m_reg[i] = 32'h0; m_busy[i] = 1'b0;
        end
        idle();
        waddr = '0; alloc_addr = '0; raddr1 = '0; raddr2 = '0; wdata = '0;
        test_reset();
        test_write_read();
        test_strobe_bypass();
        test_zero_reg();
        test_alloc();
        test_alloc_write_diff();
        test_random();
        test_reset_full();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
